// File: rtl/mult_div_unit_if.sv
// Operand, MT-write and HI/LO result bundle between the register file/control and mult_div_unit.
// Master drives operands/requests; slave returns busy, done and the HI/LO registers.
interface mult_div_unit_if;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] rs_data_i;
  logic [31:0] rt_data_i;
  logic        mthi_i;
  logic        mtlo_i;
  logic [31:0] mt_data_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport master (
    output start_i, op_i, rs_data_i, rt_data_i, mthi_i, mtlo_i, mt_data_i,
    input  busy_o, done_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, rs_data_i, rt_data_i, mthi_i, mtlo_i, mt_data_i,
    output busy_o, done_o, hi_o, lo_o
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU into HI/LO; result and done_o 34 cycles after the start edge.
// No backpressure: start_i and MTHI/MTLO are ignored (not queued) while busy_o is high.
module mult_div_unit (
  input  logic           clk,
  input  logic           rst_n,
  mult_div_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_op;
  logic [31:0] r_rs_orig;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_neg_a;
  logic        r_neg_b;
  logic [5:0]  r_cnt;
  logic [32:0] r_p;
  logic [31:0] r_q;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_done;

  // Start-time operand magnitudes; two's-complement negation maps 0x80000000 to 2^31.
  logic        w_in_signed;
  logic        w_rs_neg;
  logic        w_rt_neg;
  logic [31:0] w_rs_mag;
  logic [31:0] w_rt_mag;

  assign w_in_signed = ~bus.op_i[0];
  assign w_rs_neg    = w_in_signed & bus.rs_data_i[31];
  assign w_rt_neg    = w_in_signed & bus.rt_data_i[31];
  assign w_rs_mag    = w_rs_neg ? (~bus.rs_data_i + 32'd1) : bus.rs_data_i;
  assign w_rt_mag    = w_rt_neg ? (~bus.rt_data_i + 32'd1) : bus.rt_data_i;

  logic        w_is_div;
  logic        w_signed;
  logic [31:0] w_madd;
  logic [32:0] w_msum;
  logic [32:0] w_trial;
  logic [33:0] w_diff;
  logic        w_fits;

  assign w_is_div = r_op[1];
  assign w_signed = ~r_op[0];

  // Multiply: {r_p, r_q} is the accumulator with the multiplier shifting out of r_q LSB first.
  assign w_madd = r_q[0] ? r_a : 32'd0;
  assign w_msum = {1'b0, r_p[31:0]} + {1'b0, w_madd};

  // Divide: r_p is the partial remainder, r_q shifts dividend bits out and quotient bits in.
  assign w_trial = {r_p[31:0], r_q[31]};
  assign w_diff  = {1'b0, w_trial} - {2'b00, r_b};
  assign w_fits  = ~w_diff[33];

  logic        w_sign_diff;
  logic [63:0] w_prod;
  logic [63:0] w_prod_fix;
  logic [31:0] w_quo_fix;
  logic [31:0] w_rem_fix;

  assign w_sign_diff = w_signed & (r_neg_a ^ r_neg_b);
  assign w_prod      = {r_p[31:0], r_q};
  assign w_prod_fix  = w_sign_diff ? (~w_prod + 64'd1) : w_prod;
  assign w_quo_fix   = w_sign_diff ? (~r_q + 32'd1) : r_q;
  assign w_rem_fix   = (w_signed & r_neg_a) ? (~r_p[31:0] + 32'd1) : r_p[31:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start_i) w_state_nxt = S_CALC;
      S_CALC:  if (r_cnt == 6'd31) w_state_nxt = S_FIXUP;
      S_FIXUP: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op      <= 2'd0;
      r_rs_orig <= 32'd0;
      r_a       <= 32'd0;
      r_b       <= 32'd0;
      r_neg_a   <= 1'b0;
      r_neg_b   <= 1'b0;
      r_cnt     <= 6'd0;
      r_p       <= 33'd0;
      r_q       <= 32'd0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start_i) begin
            r_op      <= bus.op_i;
            r_rs_orig <= bus.rs_data_i;
            r_a       <= w_rs_mag;
            r_b       <= w_rt_mag;
            r_neg_a   <= w_rs_neg;
            r_neg_b   <= w_rt_neg;
            r_cnt     <= 6'd0;
            r_p       <= 33'd0;
            r_q       <= bus.op_i[1] ? w_rs_mag : w_rt_mag;
          end else begin
            if (bus.mthi_i) r_hi <= bus.mt_data_i;
            if (bus.mtlo_i) r_lo <= bus.mt_data_i;
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + 6'd1;
          if (w_is_div) begin
            r_p <= w_fits ? w_diff[32:0] : w_trial;
            r_q <= {r_q[30:0], w_fits};
          end else begin
            r_p <= {1'b0, w_msum[32:1]};
            r_q <= {w_msum[0], r_q[31:1]};
          end
        end
        S_FIXUP: begin
          r_done <= 1'b1;
          if (!w_is_div) begin
            r_hi <= w_prod_fix[63:32];
            r_lo <= w_prod_fix[31:0];
          end else if (r_b == 32'd0) begin
            r_hi <= r_rs_orig;
            r_lo <= 32'hFFFF_FFFF;
          end else begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_o = (r_state != S_IDLE);
  assign bus.done_o = r_done;
  assign bus.hi_o   = r_hi;
  assign bus.lo_o   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed vector bench for mult_div_unit: table of operations plus hand-written busy/MT/reset sequences.
module tb_mult_div_unit;

  logic clk;
  logic rst_n;
  mult_div_unit_if bus ();

  mult_div_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] eh;
    logic [31:0] el;
  } vec_t;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic [1:0] op, input logic [31:0] rs,
                     input logic [31:0] rt, input logic [31:0] eh, input logic [31:0] el);
    vec_t v;
    v.nm = nm; v.op = op; v.rs = rs; v.rt = rt; v.eh = eh; v.el = el;
    vecs.push_back(v);
  endtask

  // Starts an op in cycle 0 and observes cycles 1..40 at the falling edge.
  // inj: in cycle 5 pulse start/mthi with new operands (must be ignored while busy).
  // mtlo_w: assert mtlo_i alongside start (the MT write must be dropped).
  task automatic run_op(input vec_t v, input bit inj, input bit mtlo_w);
    logic [31:0] pre_hi, pre_lo;
    int done_cyc, done_cnt, busy_cnt;
    logic busy34;
    @(negedge clk);
    pre_hi = bus.hi_o;
    pre_lo = bus.lo_o;
    bus.start_i   = 1'b1;
    bus.op_i      = v.op;
    bus.rs_data_i = v.rs;
    bus.rt_data_i = v.rt;
    bus.mtlo_i    = mtlo_w;
    bus.mt_data_i = 32'hAAAA_5555;
    done_cyc = -1; done_cnt = 0; busy_cnt = 0; busy34 = 1'bx;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done_o === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = k;
      end
      if (k <= 33 && bus.busy_o === 1'b1) busy_cnt++;
      if (k == 34) begin
        busy34 = bus.busy_o;
        chk({v.nm, "_hi"}, {32'd0, bus.hi_o}, {32'd0, v.eh});
        chk({v.nm, "_lo"}, {32'd0, bus.lo_o}, {32'd0, v.el});
      end
      if (k == 20) begin
        chk({v.nm, "_hold_hi"}, {32'd0, bus.hi_o}, {32'd0, pre_hi});
        chk({v.nm, "_hold_lo"}, {32'd0, bus.lo_o}, {32'd0, pre_lo});
      end
      if (k == 1) begin
        bus.start_i   = 1'b0;
        bus.mtlo_i    = 1'b0;
        bus.rs_data_i = ~v.rs;
        bus.rt_data_i = v.rt + 32'd3;
      end
      if (inj && k == 5) begin
        bus.start_i   = 1'b1;
        bus.op_i      = OP_MULTU;
        bus.rs_data_i = 32'd3;
        bus.rt_data_i = 32'd3;
        bus.mthi_i    = 1'b1;
        bus.mt_data_i = 32'hDEAD_BEEF;
      end
      if (inj && k == 6) begin
        bus.start_i = 1'b0;
        bus.mthi_i  = 1'b0;
      end
    end
    chk({v.nm, "_done_cycle"}, 64'(done_cyc), 64'd34);
    chk({v.nm, "_done_count"}, 64'(done_cnt), 64'd1);
    chk({v.nm, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
    chk({v.nm, "_busy_c34"}, {63'd0, busy34}, 64'd0);
  endtask

  initial begin
    vec_t v;
    add("multu_max",   OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    add("mult_m3x7",   OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
    add("div_m7d2",    OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    add("div_7dm2",    OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    add("divu_7d0",    OP_DIVU,  32'd7,         32'd0,         32'h0000_0007, 32'hFFFF_FFFF);
    add("div_min_m1",  OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    add("mult_minsq",  OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    add("multu_shift", OP_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780);
    add("div_m8dm3",   OP_DIV,   32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h0000_0002);
    add("div_m7d0",    OP_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF);
    add("divu_maxd2",  OP_DIVU,  32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'h7FFF_FFFF);
    add("mult_m1xm1",  OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
    add("multu_zero",  OP_MULTU, 32'd0,         32'd5,         32'h0000_0000, 32'h0000_0000);

    rst_n = 1'b0;
    bus.start_i = 1'b0; bus.op_i = 2'b00; bus.rs_data_i = '0; bus.rt_data_i = '0;
    bus.mthi_i = 1'b0; bus.mtlo_i = 1'b0; bus.mt_data_i = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_hi",   {32'd0, bus.hi_o}, 64'd0);
    chk("reset_lo",   {32'd0, bus.lo_o}, 64'd0);
    chk("reset_busy", {63'd0, bus.busy_o}, 64'd0);
    chk("reset_done", {63'd0, bus.done_o}, 64'd0);

    foreach (vecs[i]) run_op(vecs[i], 1'b0, 1'b0);

    v.nm = "busy_prot"; v.op = OP_DIVU; v.rs = 32'd100; v.rt = 32'd7; v.eh = 32'd2; v.el = 32'd14;
    run_op(v, 1'b1, 1'b0);

    @(negedge clk);
    bus.mthi_i = 1'b1; bus.mtlo_i = 1'b1; bus.mt_data_i = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    bus.mthi_i = 1'b0; bus.mtlo_i = 1'b0;
    chk("mt_hi",   {32'd0, bus.hi_o}, 64'h1234_5678);
    chk("mt_lo",   {32'd0, bus.lo_o}, 64'h1234_5678);
    chk("mt_done", {63'd0, bus.done_o}, 64'd0);

    v.nm = "start_mtlo"; v.op = OP_MULTU; v.rs = 32'd6; v.rt = 32'd7; v.eh = 32'd0; v.el = 32'd42;
    run_op(v, 1'b0, 1'b1);

    @(negedge clk);
    bus.start_i = 1'b1; bus.op_i = OP_MULTU; bus.rs_data_i = 32'd5; bus.rt_data_i = 32'd5;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) bus.start_i = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("rst_mid_hi",   {32'd0, bus.hi_o}, 64'd0);
    chk("rst_mid_lo",   {32'd0, bus.lo_o}, 64'd0);
    chk("rst_mid_busy", {63'd0, bus.busy_o}, 64'd0);
    chk("rst_mid_done", {63'd0, bus.done_o}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("rst_post_done", {63'd0, bus.done_o}, 64'd0);
    chk("rst_post_lo",   {32'd0, bus.lo_o}, 64'd0);

    v.nm = "multu_5x5"; v.op = OP_MULTU; v.rs = 32'd5; v.rt = 32'd5; v.eh = 32'd0; v.el = 32'd25;
    run_op(v, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
